// File: rtl/iterative_subtractor_pkg.sv
// Shared ALU definitions for the iterative subtractor: state encoding and default geometry.
// Purely declarative; no timing or flow control of its own.
package iterative_subtractor_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int CHUNK_DEF   = 8;
  localparam int N_CHUNKS    = WIDTH_DEF / CHUNK_DEF;
  localparam int IDX_W_DEF   = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_subtractor_chunk_adder.sv
// W-bit adder slice with carry-in; also exposes the carry into its top bit for overflow.
// Purely combinational, zero latency, no flow control.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    // sum[msb] = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    c_msb_in = a[W-1] ^ b[W-1] ^ sum[W-1];
  end

endmodule

// File: rtl/iterative_subtractor.sv
// Computes A - B one CHUNK per cycle: accept, WIDTH/CHUNK RUN cycles, then DONE holds the result.
// in_ready only in IDLE; DONE holds all outputs until out_ready, with no same-cycle re-accept.
module iterative_subtractor
  import iterative_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sub_result,
  output logic             sub_cout,
  output logic             sub_overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0]       sum;
  logic                   c_out;
  logic                   c_msb;
  logic [WIDTH+CHUNK-1:0] res_cat;

  // Operands shift down each RUN cycle so the adder always sees the low chunk;
  // sums shift in from the top, leaving chunk k at bits [k*CHUNK +: CHUNK] after N steps.
  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .a        (a_q[CHUNK-1:0]),
    .b        (~b_q[CHUNK-1:0]),
    .cin      (carry_q),
    .sum      (sum),
    .cout     (c_out),
    .c_msb_in (c_msb)
  );

  assign res_cat = {sum, res_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          a_d     = data_operandA;
          b_d     = data_operandB;
          idx_d   = '0;
          carry_d = 1'b1;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_cat[WIDTH+CHUNK-1:CHUNK];
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign sub_result   = res_q;
  assign sub_cout     = cout_q;
  assign sub_overflow = ovf_q;

endmodule
